// File: rtl/timer_cpu_if.sv
// CPU peripheral bus bundle for the timer: address/write-data/strobe out of the CPU,
// registered read data and level interrupt back into it.
interface timer_cpu_if #(
    parameter int address_width = 32,
    parameter int data_width    = 32
);
    logic [address_width-1:0] address_i;
    logic [data_width-1:0]    data_i;
    logic                     rd_wr_i;
    logic [data_width-1:0]    data_o;
    logic                     irq_o;

    // rd_wr_i=1 commits data_i into the addressed register on that clock edge;
    // data_o always reflects the register selected by address_i one cycle earlier.
    modport master (output address_i, data_i, rd_wr_i, input data_o, irq_o);
    modport slave  (input address_i, data_i, rd_wr_i, output data_o, irq_o);
endinterface

// File: rtl/timer_cpu.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and level interrupt.
// Registers: CTRL, LOAD, COUNT, STATUS, PRESCALE at k*Address_Wording from BaseAddress.
module timer_cpu #(
    parameter int                       address_width   = 32,
    parameter int                       data_width      = 32,
    parameter int                       Address_Wording = 4,
    parameter logic [address_width-1:0] BaseAddress     = '0
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    timer_cpu_if.slave bus
);
    localparam int NREG = 5;
    localparam int R_CTRL = 0;
    localparam int R_LOAD = 1;
    localparam int R_COUNT = 2;
    localparam int R_STATUS = 3;
    localparam int R_PRESCALE = 4;

    logic                     en_q;
    logic                     auto_q;
    logic                     ie_q;
    logic [data_width-1:0]    load_q;
    logic [data_width-1:0]    count_q;
    logic                     exp_q;
    logic [data_width-1:0]    presc_q;
    logic [data_width-1:0]    pre_q;
    logic                     irq_q;
    logic [data_width-1:0]    rdata_q;

    logic [address_width-1:0] offset;
    logic [NREG-1:0]          sel;
    logic [NREG-1:0]          wr;
    logic                     tick;
    logic                     count_tick;
    logic                     expire;
    logic [data_width-1:0]    rdata;

    // Only exact register offsets decode; anything else (misaligned or past the end) hits nothing.
    assign offset = bus.address_i - BaseAddress;

    always_comb begin
        sel = '0;
        for (int k = 0; k < NREG; k++) begin
            sel[k] = (offset == address_width'(k * Address_Wording));
        end
    end

    assign wr = sel & {NREG{bus.rd_wr_i}};

    // A CTRL write clearing EN stops the counter on that very edge, so its tick is dropped.
    assign tick       = en_q && (pre_q == presc_q) && !(wr[R_CTRL] && !bus.data_i[0]);
    // A COUNT write swallows any tick landing on the same edge.
    assign count_tick = tick && !wr[R_COUNT];
    assign expire     = count_tick && (count_q == '0);

    always_comb begin
        rdata = '0;
        if (sel[R_CTRL])     rdata[2:0] = {ie_q, auto_q, en_q};
        if (sel[R_LOAD])     rdata      = load_q;
        if (sel[R_COUNT])    rdata      = count_q;
        if (sel[R_STATUS])   rdata[0]   = exp_q;
        if (sel[R_PRESCALE]) rdata      = presc_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            presc_q <= '0;
            pre_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // Prescaler restarts from 0 on any stop or on a 0->1 enable.
            if (wr[R_CTRL] && (!bus.data_i[0] || !en_q)) begin
                pre_q <= '0;
            end else if (en_q) begin
                pre_q <= (pre_q == presc_q) ? '0 : pre_q + data_width'(1);
            end

            // An explicit CTRL write beats the one-shot auto-disable.
            if (wr[R_CTRL]) begin
                en_q   <= bus.data_i[0];
                auto_q <= bus.data_i[1];
                ie_q   <= bus.data_i[2];
            end else if (expire && !auto_q) begin
                en_q <= 1'b0;
            end

            if (wr[R_LOAD])     load_q  <= bus.data_i;
            if (wr[R_PRESCALE]) presc_q <= bus.data_i;

            // Reload samples the pre-edge LOAD, so a same-cycle LOAD write applies next time.
            if (wr[R_COUNT]) begin
                count_q <= bus.data_i;
            end else if (count_tick) begin
                if (count_q != '0)  count_q <= count_q - data_width'(1);
                else if (auto_q)    count_q <= load_q;
            end

            if (expire)                                exp_q <= 1'b1;
            else if (wr[R_STATUS] && bus.data_i[0])    exp_q <= 1'b0;

            irq_q   <= exp_q && ie_q;
            rdata_q <= rdata;
        end
    end

    assign bus.data_o = rdata_q;
    assign bus.irq_o  = irq_q;
endmodule

// File: tb/tb_timer_cpu.sv
// Directed bench for timer_cpu: linear sequence of bus writes/reads with
// hand-computed expectations checked by immediate assertions.
module tb_timer_cpu;
    localparam logic [31:0] BASE    = 32'h0;
    localparam logic [31:0] A_CTRL  = BASE + 32'd0;
    localparam logic [31:0] A_LOAD  = BASE + 32'd4;
    localparam logic [31:0] A_COUNT = BASE + 32'd8;
    localparam logic [31:0] A_STAT  = BASE + 32'd12;
    localparam logic [31:0] A_PRE   = BASE + 32'd16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] per_seq [8];
    logic [31:0] os_stat [4];
    logic [31:0] os_irq  [4];

    timer_cpu_if #(.address_width(32), .data_width(32)) bus ();

    timer_cpu #(
        .address_width  (32),
        .data_width     (32),
        .Address_Wording(4),
        .BaseAddress    (BASE)
    ) dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.address_i = a;
        bus.data_i    = d;
        bus.rd_wr_i   = 1'b1;
        cyc();
        bus.rd_wr_i   = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string tag);
        bus.address_i = a;
        cyc();
        check(tag, bus.data_o, e);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        per_seq = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
        os_stat = '{32'd0, 32'd0, 32'd0, 32'd1};
        os_irq  = '{32'd0, 32'd0, 32'd0, 32'd1};
        rst_n = 1'b0;
        bus.address_i = '0;
        bus.data_i    = '0;
        bus.rd_wr_i   = 1'b0;

        // Reset state
        #12;
        check("rst_data_o", bus.data_o, 32'd0);
        check("rst_irq", 32'(bus.irq_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        rd_chk(A_CTRL,  32'd0, "rst_ctrl");
        rd_chk(A_LOAD,  32'd0, "rst_load");
        rd_chk(A_COUNT, 32'd0, "rst_count");
        rd_chk(A_STAT,  32'd0, "rst_stat");
        rd_chk(A_PRE,   32'd0, "rst_pre");

        // Periodic: LOAD=3, P=1 -> period 8, COUNT sequence 3,3,2,2,1,1,0,0,3...
        wr(A_LOAD, 32'd3);
        wr(A_PRE, 32'd1);
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'd7);
        bus.address_i = A_COUNT;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            check($sformatf("per_count[%0d]", k), bus.data_o, per_seq[(k - 1) % 8]);
            check($sformatf("per_irq[%0d]", k), 32'(bus.irq_o), (k >= 9) ? 32'd1 : 32'd0);
        end
        cyc();
        wr(A_CTRL, 32'd0);
        check("stop_irq_lag", 32'(bus.irq_o), 32'd1);
        cyc();
        check("stop_irq_fall", 32'(bus.irq_o), 32'd0);
        rd_chk(A_COUNT, 32'd2, "stop_count_held");
        rd_chk(A_COUNT, 32'd2, "stop_count_still");
        rd_chk(A_STAT,  32'd1, "stop_exp_kept");
        rd_chk(A_CTRL,  32'd0, "stop_ctrl");

        // Clear race: STATUS=1 written on the expiry edge
        wr(A_STAT, 32'd1);
        rd_chk(A_STAT, 32'd0, "clr_plain");
        wr(A_PRE, 32'd0);
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'd5);
        cyc();
        wr(A_STAT, 32'd1);
        rd_chk(A_STAT, 32'd1, "race_set_wins");
        check("race_irq", 32'(bus.irq_o), 32'd1);
        rd_chk(A_CTRL, 32'd4, "race_ctrl");
        wr(A_STAT, 32'd1);
        check("clr_irq_lag", 32'(bus.irq_o), 32'd1);
        cyc();
        check("clr_irq_fall", 32'(bus.irq_o), 32'd0);
        rd_chk(A_STAT, 32'd0, "clr_stat");

        // One-shot: COUNT=2, P=0 -> expiry on the third edge
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'd5);
        bus.address_i = A_STAT;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("os_stat[%0d]", k), bus.data_o, os_stat[k]);
            check($sformatf("os_irq[%0d]", k), 32'(bus.irq_o), os_irq[k]);
        end
        rd_chk(A_CTRL,  32'd4, "os_ctrl");
        rd_chk(A_COUNT, 32'd0, "os_count");
        wr(A_STAT, 32'd1);
        repeat (5) cyc();
        rd_chk(A_STAT,  32'd0, "os_no_reexp");
        rd_chk(A_COUNT, 32'd0, "os_count_hold");
        check("os_irq_low", 32'(bus.irq_o), 32'd0);

        // COUNT write on a tick edge
        wr(A_LOAD, 32'd20);
        wr(A_COUNT, 32'd15);
        wr(A_CTRL, 32'd3);
        cyc();
        cyc();
        wr(A_COUNT, 32'd9);
        rd_chk(A_COUNT, 32'd9, "cw_write_wins");
        rd_chk(A_COUNT, 32'd8, "cw_then_dec");
        wr(A_CTRL, 32'd0);

        // CTRL EN=1 write on one-shot expiry edge
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'd1);
        cyc();
        wr(A_CTRL, 32'd1);
        rd_chk(A_CTRL, 32'd1, "en_write_wins");
        rd_chk(A_CTRL, 32'd0, "en_reexpire");

        // Decode
        wr(A_COUNT, 32'd5);
        wr(A_PRE, 32'd7);
        wr(A_STAT, 32'd1);
        wr(BASE + 32'd2,  32'hFFFF_FFFF);
        wr(BASE + 32'd20, 32'hFFFF_FFFF);
        rd_chk(A_CTRL,  32'd0,  "dec_ctrl");
        rd_chk(A_LOAD,  32'd20, "dec_load");
        rd_chk(A_COUNT, 32'd5,  "dec_count");
        rd_chk(A_STAT,  32'd0,  "dec_stat");
        rd_chk(A_PRE,   32'd7,  "dec_pre");
        rd_chk(BASE + 32'd2,  32'd0, "dec_rd_misaligned");
        rd_chk(BASE + 32'd20, 32'd0, "dec_rd_past_end");
        bus.address_i = A_LOAD;
        #1;
        check("rd_latency_before", bus.data_o, 32'd0);
        cyc();
        check("rd_latency_after", bus.data_o, 32'd20);

        // Reset asserted mid-run, between edges
        wr(A_LOAD, 32'd2);
        wr(A_PRE, 32'd0);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'd7);
        bus.address_i = A_LOAD;
        cyc();
        cyc();
        check("mid_irq_high", 32'(bus.irq_o), 32'd1);
        check("mid_data", bus.data_o, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_irq", 32'(bus.irq_o), 32'd0);
        check("mid_rst_data", bus.data_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        rd_chk(A_CTRL,  32'd0, "post_ctrl");
        rd_chk(A_LOAD,  32'd0, "post_load");
        rd_chk(A_COUNT, 32'd0, "post_count");
        rd_chk(A_STAT,  32'd0, "post_stat");
        rd_chk(A_PRE,   32'd0, "post_pre");
        check("post_irq", 32'(bus.irq_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_cpu.md
# timer_cpu

Memory-mapped down-counting timer on the CPU peripheral bus, one of the external modules placed after `uart_e` in the address map. The CPU reads and writes it through the shared `address`/`data_o`/`we_o` bus. It returns read data into the registered read mux, and its interrupt is ORed into the CPU `irq_i` line. It provides periodic and one-shot interrupts with a programmable prescaler.

## Interface
- `BaseAddress`, default 0: byte address of register 0; the block occupies `BaseAddress` to `BaseAddress+4*Address_Wording`.
- `address_width`, default 32: bus address width.
- `data_width`, default 32: register and counter width.
- `Address_Wording`, default 4: byte stride between registers.

- `clk_i` in 1: system clock.
- `reset_ni` in 1: reset, asynchronous, active-low.
- `address_i` in `address_width`: CPU bus address.
- `data_i` in `data_width`: CPU write data.
- `rd_wr_i` in 1: 1 = write strobe for the current address.
- `data_o` out `data_width`: registered read data.
- `irq_o` out 1: level interrupt, registered.

## Operation
- Register offsets are `k*Address_Wording` from `BaseAddress`:
  - k=0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable). Other bits read 0.
  - k=1 LOAD: reload value, R/W.
  - k=2 COUNT: R/W; a write forces the counter value.
  - k=3 STATUS: bit0 EXP (expired flag). Read; writing 1 to bit0 clears it; writing 0 has no effect.
  - k=4 PRESCALE: R/W, value P.
- Any address that is not an exact register offset inside the range decodes to nothing: writes are ignored and reads return 0.
- Prescaler:
  - An internal counter `pre` runs only while EN=1.
  - When `pre`==P, a tick is generated and `pre` returns to 0; otherwise `pre` increments.
  - Result: one tick every P+1 cycles.
- Counter, on each tick:
  - If COUNT!=0, COUNT decrements.
  - If COUNT==0, expiry: EXP is set. If AUTO=1, COUNT is loaded with LOAD. If AUTO=0, EN is cleared and COUNT stays at 0.
- Periodic interval with AUTO=1 and LOAD=L: exactly (L+1)*(P+1) cycles.
- `irq_o` is registered EXP & IE.
- Writing CTRL with EN=0 stops the counter immediately and clears `pre`. COUNT is held.
- Writing CTRL with EN 0->1 restarts `pre` from 0. COUNT is not reloaded.
- All arithmetic is modulo 2^data_width. No underflow past 0 is possible.

## Timing
- Reset values: every register is 0, including `pre`. `data_o`=0 and `irq_o`=0.
- Reset asserted mid-count aborts everything at once. After release the block is idle (EN=0).
- Writes take effect on the clock edge where `rd_wr_i`=1. Register values are visible from the next cycle.
- Reads: `data_o` is registered from `address_i`, so the register value appears one cycle after the address is presented. This aligns with the CPU's one-cycle registered read mux. Reads have no side effects.
- Simultaneous events, each resolved as stated:
  - STATUS clear write and expiry in the same cycle: EXP ends at 1 (set wins).
  - COUNT write and tick in the same cycle: the written value wins and the tick is discarded.
  - CTRL write of EN=1 and one-shot expiry in the same cycle: the write wins and EN stays 1.
  - LOAD write during reload: the reload uses the old LOAD. The new LOAD applies from the next expiry.
- `irq_o` rises one cycle after EXP is set and falls one cycle after EXP clears or IE is cleared.
- P=0 gives a tick every cycle while EN=1.

## Test plan
- **Reset.** Assert `reset_ni`=0 mid-run, asynchronously between edges. Required: `irq_o`=0 and `data_o`=0 immediately. Every register reads 0 after release.
- **Periodic.** Program LOAD=3, PRESCALE=1, COUNT=3, then CTRL=0b111. Required: EXP sets every 8 cycles. `irq_o` is high 1 cycle after each EXP set. COUNT reads the sequence 3,3,2,2,1,1,0,0,3.
- **One-shot.** Program COUNT=2, P=0, then CTRL=0b101. Required: expiry after 3 cycles, CTRL reads 0b100 afterwards, and COUNT holds at 0 with no further EXP.
- **Clear race.** Write STATUS=1 on the exact expiry cycle. Required: EXP reads 1. A later STATUS=1 write with no expiry clears EXP, and `irq_o` drops 1 cycle later.
- **Decode.** Write 0xFFFF_FFFF to `BaseAddress`+2 and to `BaseAddress`+20. Required: no register changes and both reads return 0. Reading LOAD returns data 1 cycle after the address is presented.
- **COUNT write vs tick.** Write COUNT=9 on a tick cycle. Required: COUNT reads 9 (not 8) in the next cycle.
